gray_mod_counter: RTL

//  Parametrised modulo-N up/down counter with Gray-coded output, synchronous load,
//  and a registered terminal-count (carry/borrow) pulse.

---
 rtl/gray_mod_counter_pkg.sv | 14 +
 rtl/gray_mod_counter_if.sv | 9 +
 rtl/gray_mod_counter_next.sv | 35 +++
 rtl/gray_mod_counter.sv | 36 +++
 4 files changed

// File: rtl/gray_mod_counter_pkg.sv
// gray_counter_pkg: shared direction type, clog2 helper and binary-to-Gray conversion
package gray_counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Callers size-cast the result back to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_mod_counter_if.sv
// gray_mod_counter_if: control and output bundle of gray_mod_counter
//   en, up, load, din : master -> counter (count enable, direction, load strobe, load value)
//   q_bin, q, cout    : counter -> master (binary count, output code, wrap pulse)
interface gray_mod_counter_if #(parameter int WIDTH = 4);
  logic en, up, load, cout;
  logic [WIDTH-1:0] din, q_bin, q;
  modport master (output en, up, load, din, input q_bin, q, cout);
  modport slave (input en, up, load, din, output q_bin, q, cout);
endinterface

// File: rtl/gray_mod_counter_next.sv
// gray_mod_next: next-state logic of the modulo counter (next binary value, wrap flag, output code)
//   in : q_bin, up, load, en, din    out : nxt, nxt_code, wrap
//   GRAY_MOD_COUNTER_GRAY_OUT_EN selects Gray output code; otherwise nxt_code == nxt
module gray_mod_next
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 11
) (
  input  logic [WIDTH-1:0] q_bin,
  input  logic             up,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] nxt_code,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  logic is_up, at_end;
  logic [WIDTH-1:0] step;
  // Wrap is detected before stepping, so no intermediate value ever leaves 0..MODULUS-1.
  always_comb begin
    is_up = dir_e'(up) == DIR_UP;
    at_end = is_up ? (q_bin == TOP) : (q_bin == '0);
    step = at_end ? (is_up ? '0 : TOP) : (is_up ? q_bin + WIDTH'(1) : q_bin - WIDTH'(1));
    nxt = load ? ((din > TOP) ? TOP : din) : (en ? step : q_bin);
    wrap = !load && en && at_end;
  end
`ifdef GRAY_MOD_COUNTER_GRAY_OUT_EN
  assign nxt_code = WIDTH'(bin2gray(32'(nxt)));
`else
  assign nxt_code = nxt;
`endif
endmodule

// File: rtl/gray_mod_counter.sv
// gray_mod_counter: modulo-MODULUS up/down counter with Gray-coded output, clamped load and wrap pulse
//   clk : rising-edge clock    clr : asynchronous active-low reset
//   bus : gray_mod_counter_if.slave (en, up, load, din in; q_bin, q, cout out)
//   GRAY_MOD_COUNTER_GRAY_OUT_EN defined -> q is Gray code; undefined -> q == q_bin
module gray_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MODULUS = 11
) (
  input logic clk,
  input logic clr,
  gray_mod_counter_if.slave bus
);
  logic [WIDTH-1:0] nxt, nxt_code;
  logic wrap;
  gray_mod_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .q_bin(bus.q_bin),
    .up(bus.up),
    .load(bus.load),
    .en(bus.en),
    .din(bus.din),
    .nxt(nxt),
    .nxt_code(nxt_code),
    .wrap(wrap)
  );
  // The output code is derived from the next value, so q and q_bin update on the same edge.
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      bus.q_bin <= '0;
      bus.q <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.q_bin <= nxt;
      bus.q <= nxt_code;
      bus.cout <= wrap;
    end
endmodule
